noc_router_xy: RTL and testbench
================================

# noc_router_xy

Parametrised 5-port wormhole mesh router with XY dimension-order routing, per-input flit buffers, round-robin output allocation and credit-based flow control. It is the next-generation tile router instantiated once per mesh node by the NoC top, replacing the fixed-size router. Neighbouring routers connect output port p to the opposite input port of the adjacent tile, and port 4 attaches to the local network interface.

## Interface
Parameters:
- DATA_W, 32, flit payload width; must be ≥ X_W+Y_W.
- X_W, 2, width of x coordinate.
- Y_W, 2, width of y coordinate.
- MESH_X_NUM, 4, mesh columns; legal dst_x is 0..MESH_X_NUM-1.
- MESH_Y_NUM, 4, mesh rows; legal dst_y is 0..MESH_Y_NUM-1.
- DEPTH, 4, input buffer depth in flits, power of two, ≥2; also the initial credit count.

Ports (array index = port: 0 N, 1 E, 2 S, 3 W, 4 Local):
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- my_x  in  X_W  tile x coordinate, static.
- my_y  in  Y_W  tile y coordinate, static.
- in_valid[5]  in  1  flit present on in_flit this cycle.
- in_flit[5]  in  flit_t  incoming flit.
- in_credit[5]  out  1  one-cycle pulse: one slot freed in that input buffer.
- out_valid[5]  out  1  flit present on out_flit.
- out_flit[5]  out  flit_t  outgoing flit.
- out_credit[5]  in  1  one-cycle pulse from downstream: one slot freed.
- err  out  1  sticky error flag.

## Operation
- flit_t = {head, tail, payload[DATA_W-1:0]}; on a head flit payload[X_W+Y_W-1:0] = {dst_x, dst_y}. head&tail is a single-flit packet.
- Input buffer: FIFO of DEPTH; write on in_valid; on write while full, the flit is dropped and err is set.
- Route (head flit at FIFO front): dst_x>my_x → E; dst_x<my_x → W; else dst_y>my_y → S; dst_y<my_y → N; else Local. Route is latched per input and held until its tail pops.
- Illegal destination (dst_x≥MESH_X_NUM or dst_y≥MESH_Y_NUM) or route equal to the arrival port (U-turn, Local excepted): set err; the packet is drained (flits popped, credits returned, nothing forwarded).
- Per-input FSM: IDLE (no head at front) → ROUTE (head present, requesting output) → ACTIVE (owns output) → IDLE after tail pops; DRAIN replaces ROUTE/ACTIVE for illegal packets.
- Per-output allocation: free output grants one requester round-robin, priority starting after last winner; it stays locked to the owner until the owner's tail is sent. A head&tail flit is granted and released in the same cycle.
- Credit counter per output, 0..DEPTH, reset DEPTH: −1 on send, +1 on out_credit, both in the same cycle → unchanged. No send when 0.
- Send condition: input owns or wins output, FIFO non-empty, credit>0. At most one flit per output and one pop per input per cycle.
- Non-head flit at an IDLE input (protocol violation): set err, drop it, return credit.

## Timing
- Reset values: out_valid=0, out_flit=0, in_credit=0, err=0, FIFOs empty, credits=DEPTH, all locks free, RR pointers 0.
- Latency: flit sampled at edge t → out_valid high after edge t+2 (1 buffer + 1 output register), with free output and credit available.
- in_credit pulses for one cycle after the edge on which the flit popped.
- Streaming: back-to-back flits of a locked packet forward one per cycle while credit>0.
- Reset asserted mid-packet: all state returns to reset values immediately; partial packets are discarded.
- err clears only on reset.

## Structure
- noc_pkg: flit_t, port enum (PORT_N..PORT_L), NUM_PORTS=5, opposite-port function.
- Sub-module noc_flit_fifo (DEPTH, flit_t; push, pop, full, empty, front) is instantiated 5×.
- Round-robin arbiter is inline or a small noc_rr_arb.

## Test plan
- Tile (1,1), head+tail flit dst (3,1) on Local → out_valid[E] after 2 cycles, in_credit[4] pulse once.
- 4-flit packet N→dst (1,1) and 4-flit packet W→dst (1,1) simultaneously → Local carries one packet contiguously, then the other; no interleaving.
- out_credit[E] held 0, 6 flits to E with DEPTH=4 → exactly 4 sent, remainder buffered; one credit pulse → one more sent.
- Send and out_credit on the same cycle at credit=1 → counter stays 1 and the next flit is sent.
- Head with dst (5,0) on 4×4 → err=1, packet drained, no out_valid, credits returned.
- Reset asserted mid-packet → all outputs 0, credits 4, and the subsequent packet routes normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types for the XY mesh router: port numbering, input FSM states and
// the default-width flit layout {head, tail, payload}.
package noc_pkg;

  localparam int NUM_PORTS   = 5;
  localparam int PORT_IDX_W  = 3;
  localparam int FLIT_DATA_W = 32;

  typedef enum logic [PORT_IDX_W-1:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_S = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_ACTIVE,
    ST_DRAIN
  } in_state_e;

  typedef struct packed {
    logic                   head;
    logic                   tail;
    logic [FLIT_DATA_W-1:0] payload;
  } flit_t;

  function automatic port_e opposite_port(input port_e p);
    case (p)
      PORT_N:  return PORT_S;
      PORT_E:  return PORT_W;
      PORT_S:  return PORT_N;
      PORT_W:  return PORT_E;
      default: return PORT_L;
    endcase
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Per-input flit buffer: DEPTH-entry circular FIFO with a combinational front.
// A push while full is ignored; the router flags that as an error.
module noc_flit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] front
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign front   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/noc_router_xy.sv
// 5-port wormhole mesh router: XY routing, per-input FIFOs, round-robin output
// locking per packet and credit-based flow control toward each neighbour.
module noc_router_xy
  import noc_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter int MESH_X_NUM = 4,
  parameter int MESH_Y_NUM = 4,
  parameter int DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [X_W-1:0]                       my_x,
  input  logic [Y_W-1:0]                       my_y,
  input  logic [NUM_PORTS-1:0]                 in_valid,
  input  logic [NUM_PORTS-1:0][DATA_W+1:0]     in_flit,
  output logic [NUM_PORTS-1:0]                 in_credit,
  output logic [NUM_PORTS-1:0]                 out_valid,
  output logic [NUM_PORTS-1:0][DATA_W+1:0]     out_flit,
  input  logic [NUM_PORTS-1:0]                 out_credit,
  output logic                                 err
);

  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              head;
    logic              tail;
    logic [DATA_W-1:0] payload;
  } flit_w_t;

  flit_w_t                fifo_front [NUM_PORTS];
  logic [NUM_PORTS-1:0]   fifo_full, fifo_empty, fifo_pop;

  in_state_e              state_q [NUM_PORTS], state_d [NUM_PORTS];
  port_e                  route_q [NUM_PORTS], route_d [NUM_PORTS];
  logic [PORT_IDX_W-1:0]  owner_q [NUM_PORTS], owner_d [NUM_PORTS];
  logic [PORT_IDX_W-1:0]  rr_ptr_q [NUM_PORTS], rr_ptr_d [NUM_PORTS];
  logic [CW-1:0]          credit_q [NUM_PORTS], credit_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]   lock_q, lock_d;
  logic [NUM_PORTS-1:0]   out_valid_q, out_valid_d;
  logic [NUM_PORTS-1:0][FW-1:0] out_flit_q, out_flit_d;
  logic [NUM_PORTS-1:0]   in_credit_q, in_credit_d;
  logic                   err_q, err_d;

  port_e                  head_route [NUM_PORTS];
  logic [NUM_PORTS-1:0]   head_illegal;
  logic [NUM_PORTS-1:0]   send;

  // Nearest requester after the last winner; the last winner itself ranks lowest.
  function automatic logic [PORT_IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                    input logic [PORT_IDX_W-1:0] ptr);
    logic [PORT_IDX_W-1:0] pick;
    int idx;
    pick = ptr;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_PORTS;
      if (req[idx]) pick = PORT_IDX_W'(idx);
    end
    return pick;
  endfunction

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
    noc_flit_fifo #(
      .DEPTH (DEPTH),
      .W     (FW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid[g]),
      .pop   (fifo_pop[g]),
      .din   (in_flit[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g]),
      .front (fifo_front[g])
    );
  end

  always_comb begin
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    for (int i = 0; i < NUM_PORTS; i++) begin
      dx = fifo_front[i].payload[X_W+Y_W-1:Y_W];
      dy = fifo_front[i].payload[Y_W-1:0];
      if (dx > my_x)      head_route[i] = PORT_E;
      else if (dx < my_x) head_route[i] = PORT_W;
      else if (dy > my_y) head_route[i] = PORT_S;
      else if (dy < my_y) head_route[i] = PORT_N;
      else                head_route[i] = PORT_L;
      head_illegal[i] = (int'(dx) >= MESH_X_NUM) || (int'(dy) >= MESH_Y_NUM) ||
                        ((head_route[i] == port_e'(i)) && (i != int'(PORT_L)));
    end
  end

  always_comb begin
    logic [NUM_PORTS-1:0]  req;
    logic [PORT_IDX_W-1:0] sel;
    logic                  go;

    state_d     = state_q;
    route_d     = route_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    credit_d    = credit_q;
    lock_d      = lock_q;
    out_valid_d = '0;
    out_flit_d  = out_flit_q;
    fifo_pop    = '0;
    send        = '0;
    err_d       = err_q || |(in_valid & fifo_full);
    req         = '0;
    sel         = '0;
    go          = 1'b0;

    // Input side: route decode, protocol-violation drops and draining.
    for (int i = 0; i < NUM_PORTS; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (!fifo_empty[i]) begin
            if (!fifo_front[i].head) begin
              fifo_pop[i] = 1'b1;
              err_d       = 1'b1;
            end else if (head_illegal[i]) begin
              state_d[i] = ST_DRAIN;
              err_d      = 1'b1;
            end else begin
              state_d[i] = ST_ROUTE;
              route_d[i] = head_route[i];
            end
          end
        end
        ST_DRAIN: begin
          if (!fifo_empty[i]) begin
            fifo_pop[i] = 1'b1;
            if (fifo_front[i].tail) state_d[i] = ST_IDLE;
          end
        end
        default: ;
      endcase
    end

    // Output side: locked owner streams, otherwise a free output arbitrates.
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[i] = (state_q[i] == ST_ROUTE) && (route_q[i] == port_e'(o));
      end
      sel = owner_q[o];
      go  = 1'b0;
      if (credit_q[o] != '0) begin
        if (lock_q[o]) begin
          go = !fifo_empty[owner_q[o]];
        end else if (|req) begin
          sel         = rr_pick(req, rr_ptr_q[o]);
          rr_ptr_d[o] = sel;
          go          = 1'b1;
        end
      end
      if (go) begin
        send[o]        = 1'b1;
        fifo_pop[sel]  = 1'b1;
        out_valid_d[o] = 1'b1;
        out_flit_d[o]  = fifo_front[sel];
        owner_d[o]     = sel;
        lock_d[o]      = !fifo_front[sel].tail;
        state_d[sel]   = fifo_front[sel].tail ? ST_IDLE : ST_ACTIVE;
      end
      case ({send[o], out_credit[o]})
        2'b10:   credit_d[o] = credit_q[o] - 1'b1;
        2'b01:   if (credit_q[o] != CW'(DEPTH)) credit_d[o] = credit_q[o] + 1'b1;
        default: ;
      endcase
    end

    in_credit_d = fifo_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i]  <= ST_IDLE;
        route_q[i]  <= PORT_L;
        owner_q[i]  <= '0;
        rr_ptr_q[i] <= '0;
        credit_q[i] <= CW'(DEPTH);
      end
      lock_q      <= '0;
      out_valid_q <= '0;
      out_flit_q  <= '0;
      in_credit_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      credit_q    <= credit_d;
      lock_q      <= lock_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      in_credit_q <= in_credit_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign in_credit = in_credit_q;
  assign err       = err_q;

endmodule

// File: tb/tb_noc_router_xy.sv
// Scoreboard bench for noc_router_xy on tile (1,1) of a 4x4 mesh with 3-bit
// coordinates so that out-of-mesh destinations can be encoded.
module tb_noc_router_xy;

  localparam int DW = 32;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int FW = DW + 2;
  localparam int NP = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [XW-1:0]         my_x = 3'd1;
  logic [YW-1:0]         my_y = 3'd1;
  logic [NP-1:0]         in_valid = '0;
  logic [NP-1:0][FW-1:0] in_flit = '0;
  logic [NP-1:0]         in_credit;
  logic [NP-1:0]         out_valid;
  logic [NP-1:0][FW-1:0] out_flit;
  logic [NP-1:0]         out_credit;
  logic                  err;

  logic [NP-1:0]         sink_en = '1;
  logic [NP-1:0]         man_credit = '0;
  logic [FW-1:0]         exp_q [NP][$];
  int                    n_out [NP];
  int                    n_cred [NP];
  int                    checks = 0;
  int                    errors = 0;
  int                    base;

  noc_router_xy #(
    .DATA_W     (DW),
    .X_W        (XW),
    .Y_W        (YW),
    .MESH_X_NUM (4),
    .MESH_Y_NUM (4),
    .DEPTH      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .my_x       (my_x),
    .my_y       (my_y),
    .in_valid   (in_valid),
    .in_flit    (in_flit),
    .in_credit  (in_credit),
    .out_valid  (out_valid),
    .out_flit   (out_flit),
    .out_credit (out_credit),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic h, input logic t, input int dx,
                                       input int dy, input int tag);
    logic [DW-1:0] pl;
    pl = {tag[25:0], dx[2:0], dy[2:0]};
    return {h, t, pl};
  endfunction

  // XY rule for tile (1,1): expected output port for a legal destination.
  function automatic int route_of(input int dx, input int dy);
    if (dx > 1) return 1;
    if (dx < 1) return 3;
    if (dy > 1) return 2;
    if (dy < 1) return 0;
    return 4;
  endfunction

  task automatic put(input int p, input logic [FW-1:0] f, input int r);
    in_valid[p] = 1'b1;
    in_flit[p]  = f;
    if (r >= 0) exp_q[r].push_back(f);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = '0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = '0;
    man_credit = '0;
    sink_en    = '1;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic credit_pulse(input int p);
    man_credit[p] = 1'b1;
    tick();
    man_credit[p] = 1'b0;
  endtask

  // Downstream sink and scoreboard: compares every forwarded flit in order.
  initial begin
    out_credit = '0;
    for (int p = 0; p < NP; p++) begin
      n_out[p]  = 0;
      n_cred[p] = 0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (!rst && out_valid[p]) begin
          n_out[p]++;
          if (exp_q[p].size() == 0) begin
            check($sformatf("unexpected_out_p%0d", p), 64'd1, 64'd0);
          end else begin
            check($sformatf("flit_p%0d", p), 64'(out_flit[p]), 64'(exp_q[p].pop_front()));
          end
        end
        if (!rst && in_credit[p]) n_cred[p]++;
        out_credit[p] = (!rst && out_valid[p] && sink_en[p]) || man_credit[p];
      end
    end
  end

  initial begin
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_flit", 64'(out_flit), 64'd0);
    check("rst_in_credit", 64'(in_credit), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    do_reset();

    // Single-flit packet Local -> E: two-cycle latency, one credit pulse.
    base = n_cred[4];
    put(4, mk(1, 1, 3, 1, 16'h1001), route_of(3, 1));
    tick();
    check("lat_e1", 64'(out_valid[1]), 64'd0);
    tick();
    check("lat_e2", 64'(out_valid[1]), 64'd0);
    tick();
    check("lat_e3", 64'(out_valid[1]), 64'd1);
    check("cred_l_on", 64'(in_credit[4]), 64'd1);
    tick();
    check("lat_e4", 64'(out_valid[1]), 64'd0);
    check("cred_l_off", 64'(in_credit[4]), 64'd0);
    repeat (3) tick();
    check("cred_l_count", 64'(n_cred[4] - base), 64'd1);
    check("t1_drained", 64'(exp_q[1].size()), 64'd0);

    // Two 4-flit packets to Local from N and W: W wins first, no interleave.
    do_reset();
    for (int k = 0; k < 4; k++)
      exp_q[4].push_back(mk(k == 0, k == 3, 1, 1, 16'h3300 + k));
    for (int k = 0; k < 4; k++)
      exp_q[4].push_back(mk(k == 0, k == 3, 1, 1, 16'h0000 + k));
    for (int k = 0; k < 4; k++) begin
      put(0, mk(k == 0, k == 3, 1, 1, 16'h0000 + k), -1);
      put(3, mk(k == 0, k == 3, 1, 1, 16'h3300 + k), -1);
      tick();
    end
    repeat (14) tick();
    check("t2_drained", 64'(exp_q[4].size()), 64'd0);
    check("t2_err", 64'(err), 64'd0);

    // Credit stall: six flits to E with no returned credit, then two pulses.
    do_reset();
    sink_en[1] = 1'b0;
    base = n_out[1];
    for (int k = 0; k < 6; k++) begin
      put(4, mk(k == 0, k == 5, 3, 1, 16'h2000 + k), route_of(3, 1));
      tick();
    end
    repeat (6) tick();
    check("stall_sent4", 64'(n_out[1] - base), 64'd4);
    check("stall_held2", 64'(exp_q[1].size()), 64'd2);
    credit_pulse(1);
    repeat (4) tick();
    check("stall_sent5", 64'(n_out[1] - base), 64'd5);
    credit_pulse(1);
    repeat (4) tick();
    check("stall_sent6", 64'(n_out[1] - base), 64'd6);
    check("stall_err", 64'(err), 64'd0);

    // Send and credit return on the same edge at credit=1.
    do_reset();
    sink_en[1] = 1'b0;
    base = n_out[1];
    for (int k = 0; k < 3; k++) begin
      put(4, mk(k == 0, 1'b0, 3, 1, 16'h4000 + k), route_of(3, 1));
      tick();
    end
    repeat (5) tick();
    check("same_sent3", 64'(n_out[1] - base), 64'd3);
    put(4, mk(1'b0, 1'b0, 3, 1, 16'h4003), route_of(3, 1));
    tick();
    credit_pulse(1);
    repeat (3) tick();
    check("same_sent4", 64'(n_out[1] - base), 64'd4);
    put(4, mk(1'b0, 1'b1, 3, 1, 16'h4004), route_of(3, 1));
    tick();
    repeat (3) tick();
    check("same_sent5", 64'(n_out[1] - base), 64'd5);
    check("same_drained", 64'(exp_q[1].size()), 64'd0);

    // Illegal destination (5,0): error, drained, credits returned, nothing sent.
    do_reset();
    check("ill_err_pre", 64'(err), 64'd0);
    base = n_cred[4];
    put(4, mk(1, 0, 5, 0, 16'h5000), -1);
    tick();
    put(4, mk(0, 0, 5, 0, 16'h5001), -1);
    tick();
    put(4, mk(0, 1, 5, 0, 16'h5002), -1);
    tick();
    repeat (6) tick();
    check("ill_err", 64'(err), 64'd1);
    check("ill_credits", 64'(n_cred[4] - base), 64'd3);
    repeat (3) tick();
    check("ill_err_sticky", 64'(err), 64'd1);

    // Reset mid-packet, then a fresh packet must see all four credits.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      put(4, mk(k == 0, 1'b0, 3, 1, 16'h6000 + k), route_of(3, 1));
      tick();
    end
    tick();
    #2;
    rst = 1'b1;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    #1;
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_out_flit", 64'(out_flit), 64'd0);
    check("mid_in_credit", 64'(in_credit), 64'd0);
    check("mid_err", 64'(err), 64'd0);
    do_reset();
    sink_en[1] = 1'b0;
    base = n_out[1];
    for (int k = 0; k < 4; k++) begin
      put(4, mk(k == 0, k == 3, 3, 1, 16'h7000 + k), route_of(3, 1));
      tick();
    end
    repeat (6) tick();
    check("post_rst_sent4", 64'(n_out[1] - base), 64'd4);
    check("post_rst_drained", 64'(exp_q[1].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
